chunked_adder: RTL and testbench

- Parametrised, multi-cycle successor to the ALU's bitwise half-adder stage.
- Adds or subtracts two WIDTH-bit operands with a ripple of CHUNK bits per clock.
- Each chunk is formed from half-adder XOR/AND terms, and the carry is held in a register between chunks.
- Sits between the ALU operand registers and the result mux. Exposes a start/done handshake plus Carry-out, signed Overflow and Zero flags.

---
 rtl/chunked_adder.sv | 160 ++++++++++++++++
 tb/tb_chunked_adder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunked_adder
// Purpose  : Multi-cycle WIDTH-bit adder/subtractor. Processes CHUNK bits per
//            clock using per-bit half-adder terms (p = a^b, g = a&b) with a
//            rippled carry. The carry is held in a register between chunks.
//            Subtraction is A + ~B + 1, so Cin is ignored in that mode.
// Ports    : clk      - clock, all state changes on the rising edge
//            reset    - synchronous active-high reset
//            Start    - request a new operation (sampled only when not Busy)
//            Sub      - 0: A+B+Cin, 1: A-B
//            Cin      - carry-in for add mode
//            A, B     - operands, captured on the accepted Start
//            Sum      - registered result, held until the next accepted Start
//            Carry    - carry-out of the MSB (1 = no borrow in Sub mode)
//            Overflow - signed overflow of the result
//            Zero     - result equals zero
//            Busy     - high while slices are being processed
//            Done     - one-cycle pulse when the result is valid
// Revision : 1.0 - initial release
// ============================================================================
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    // WIDTH must be a multiple of CHUNK and CHUNK must be at least 1.
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              c_q;        // carry held between slices
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;        // already inverted for subtraction
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              ovf_q;
    logic              zero_q;
    logic              busy_q;
    logic              done_q;

    logic [31:0]       w_base;
    logic [CHUNK-1:0]  w_a_sl;
    logic [CHUNK-1:0]  w_b_sl;
    logic [CHUNK-1:0]  w_p;
    logic [CHUNK-1:0]  w_g;
    logic [CHUNK-1:0]  w_s;
    logic [CHUNK:0]    w_carry;
    logic [WIDTH-1:0]  sum_d;

    assign w_base = 32'(idx_q) * CHUNK;

    // Slice datapath: half-adder propagate/generate terms per bit, carry
    // rippled from the registered carry of the previous slice.
    always_comb begin
        w_a_sl     = a_q[w_base +: CHUNK];
        w_b_sl     = b_q[w_base +: CHUNK];
        w_p        = '0;
        w_g        = '0;
        w_s        = '0;
        w_carry    = '0;
        w_carry[0] = c_q;
        for (int j = 0; j < CHUNK; j++) begin
            w_p[j]       = w_a_sl[j] ^ w_b_sl[j];
            w_g[j]       = w_a_sl[j] & w_b_sl[j];
            w_s[j]       = w_p[j] ^ w_carry[j];
            w_carry[j+1] = w_g[j] | (w_p[j] & w_carry[j]);
        end
        sum_d                   = sum_q;
        sum_d[w_base +: CHUNK]  = w_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        a_q     <= A;
                        b_q     <= Sub ? ~B : B;
                        c_q     <= Sub ? 1'b1 : Cin;
                        sum_q   <= '0;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        zero_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum_q <= sum_d;
                    c_q   <= w_carry[CHUNK];
                    idx_q <= idx_q + IDXW'(1);
                    if (idx_q == IDX_LAST) begin
                        // Last slice holds the MSB: its carry-in and
                        // carry-out decide signed overflow.
                        idx_q   <= '0;
                        carry_q <= w_carry[CHUNK];
                        ovf_q   <= w_carry[CHUNK-1] ^ w_carry[CHUNK];
                        zero_q  <= (sum_d == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Sum      = sum_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_adder
// Purpose  : Self-checking bench for chunked_adder. Four instances cover
//            (WIDTH,CHUNK) = (32,8), (32,32), (16,4), (8,1). An arithmetic
//            model predicts Sum/Carry/Overflow/Zero/Busy/Done every cycle;
//            directed vectors on the (32,8) instance pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_adder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_v [4];
    logic [31:0] b_v [4];
    logic        start_v [4];
    logic        sub_v [4];
    logic        cin_v [4];

    logic [31:0] sum0;
    logic [31:0] sum1;
    logic [15:0] sum2;
    logic [7:0]  sum3;
    logic [31:0] sum_v [4];
    logic        carry_v [4];
    logic        ovf_v [4];
    logic        zero_v [4];
    logic        busy_v [4];
    logic        done_v [4];

    always_comb begin
        sum_v[0] = sum0;
        sum_v[1] = sum1;
        sum_v[2] = {16'd0, sum2};
        sum_v[3] = {24'd0, sum3};
    end

    chunked_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .reset(reset), .Start(start_v[0]), .Sub(sub_v[0]),
        .Cin(cin_v[0]), .A(a_v[0]), .B(b_v[0]), .Sum(sum0),
        .Carry(carry_v[0]), .Overflow(ovf_v[0]), .Zero(zero_v[0]),
        .Busy(busy_v[0]), .Done(done_v[0]));

    chunked_adder #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clk(clk), .reset(reset), .Start(start_v[1]), .Sub(sub_v[1]),
        .Cin(cin_v[1]), .A(a_v[1]), .B(b_v[1]), .Sum(sum1),
        .Carry(carry_v[1]), .Overflow(ovf_v[1]), .Zero(zero_v[1]),
        .Busy(busy_v[1]), .Done(done_v[1]));

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut2 (
        .clk(clk), .reset(reset), .Start(start_v[2]), .Sub(sub_v[2]),
        .Cin(cin_v[2]), .A(a_v[2][15:0]), .B(b_v[2][15:0]), .Sum(sum2),
        .Carry(carry_v[2]), .Overflow(ovf_v[2]), .Zero(zero_v[2]),
        .Busy(busy_v[2]), .Done(done_v[2]));

    chunked_adder #(.WIDTH(8), .CHUNK(1)) u_dut3 (
        .clk(clk), .reset(reset), .Start(start_v[3]), .Sub(sub_v[3]),
        .Cin(cin_v[3]), .A(a_v[3][7:0]), .B(b_v[3][7:0]), .Sum(sum3),
        .Carry(carry_v[3]), .Overflow(ovf_v[3]), .Zero(zero_v[3]),
        .Busy(busy_v[3]), .Done(done_v[3]));

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int cfg_w(input int k);
        case (k)
            0: return 32;
            1: return 32;
            2: return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_nch(input int k);
        case (k)
            0: return 4;
            1: return 1;
            2: return 4;
            default: return 8;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference arithmetic: plain wide addition, then flags from the
    // sign rule (same-sign operands producing a different-sign result).
    function automatic void ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub,
                                   output logic [31:0] s, output logic c, output logic v);
        logic [63:0] mask, aa, bb, full;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
        full = aa + bb + {63'd0, (sub ? 1'b1 : cin)};
        s    = 32'(full & mask);
        c    = full[w];
        v    = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    endfunction

    // Cycle-level model: an operation accepted at cycle E completes
    // at cycle E + NCH.
    int          cyc = 0;
    logic        m_busy [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic        m_done [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] m_sum  [4];
    logic        m_c    [4];
    logic        m_v    [4];
    logic        m_z    [4];
    logic [31:0] p_sum  [4];
    logic        p_c    [4];
    logic        p_v    [4];
    int          m_due  [4];

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            m_done[k] = 1'b0;
            if (reset) begin
                m_busy[k] = 1'b0;
                m_sum[k]  = 32'd0;
                m_c[k]    = 1'b0;
                m_v[k]    = 1'b0;
                m_z[k]    = 1'b0;
            end else if (m_busy[k]) begin
                if (cyc == m_due[k]) begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b1;
                    m_sum[k]  = p_sum[k];
                    m_c[k]    = p_c[k];
                    m_v[k]    = p_v[k];
                    m_z[k]    = (p_sum[k] == 32'd0);
                end
            end else if (start_v[k]) begin
                ref_op(cfg_w(k), a_v[k], b_v[k], cin_v[k], sub_v[k], p_sum[k], p_c[k], p_v[k]);
                m_due[k]  = cyc + cfg_nch(k);
                m_busy[k] = 1'b1;
                m_sum[k]  = 32'd0;
                m_c[k]    = 1'b0;
                m_v[k]    = 1'b0;
                m_z[k]    = 1'b0;
            end
        end
    end

    // Compare process: handshake every cycle, result flags whenever not busy.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int k = 0; k < 4; k++) begin
                chk1($sformatf("k%0d busy", k), busy_v[k], m_busy[k]);
                chk1($sformatf("k%0d done", k), done_v[k], m_done[k]);
                if (!m_busy[k]) begin
                    chk($sformatf("k%0d sum", k), sum_v[k], m_sum[k]);
                    chk1($sformatf("k%0d carry", k), carry_v[k], m_c[k]);
                    chk1($sformatf("k%0d overflow", k), ovf_v[k], m_v[k]);
                    chk1($sformatf("k%0d zero", k), zero_v[k], m_z[k]);
                end
            end
        end
    end

    // Counts negedges after the accepting edge until Done; NCH+1 expected.
    task automatic wait_done(input int k, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done_v[k] && lat < 64);
        if (!done_v[k]) chk($sformatf("k%0d done timeout", k), 32'(lat), 32'(cfg_nch(k) + 1));
    endtask

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, output int lat);
        @(posedge clk);
        #2;
        a_v[k] = a; b_v[k] = b; cin_v[k] = cin; sub_v[k] = sub; start_v[k] = 1'b1;
        @(posedge clk);
        #2;
        start_v[k] = 1'b0;
        wait_done(k, lat);
    endtask

    task automatic check_lit(input string name, input logic [31:0] s, input logic c,
                             input logic v, input logic z);
        chk({name, " sum"}, sum_v[0], s);
        chk1({name, " carry"}, carry_v[0], c);
        chk1({name, " overflow"}, ovf_v[0], v);
        chk1({name, " zero"}, zero_v[0], z);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;
        for (int k = 0; k < 4; k++) begin
            a_v[k] = '0; b_v[k] = '0; start_v[k] = 1'b0; sub_v[k] = 1'b0; cin_v[k] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check_lit("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        chk1("reset busy", busy_v[0], 1'b0);
        chk1("reset done", done_v[0], 1'b0);

        // Full-width carry ripple to zero, with latency and pulse width
        run_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        chk("wrap latency", 32'(lat), 32'd5);
        check_lit("wrap", 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk1("done pulse width", done_v[0], 1'b0);
        check_lit("wrap hold", 32'h0, 1'b1, 1'b0, 1'b1);

        run_op(0, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, lat);
        check_lit("chunk boundary", 32'h0000_0100, 1'b0, 1'b0, 1'b0);

        run_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        check_lit("pos overflow", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        run_op(0, 32'd5, 32'd7, 1'b1, 1'b1, lat);
        check_lit("sub borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        run_op(0, 32'h8000_0000, 32'h1, 1'b1, 1'b1, lat);
        check_lit("sub overflow", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Start held through RUN with operands changing, then back-to-back
        @(posedge clk);
        #2;
        a_v[0] = 32'h1234_5678; b_v[0] = 32'h1111_1111; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #2;
        a_v[0] = 32'h10; b_v[0] = 32'h20; cin_v[0] = 1'b1;
        wait_done(0, lat);
        chk("held start latency", 32'(lat), 32'd5);
        check_lit("held start", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        start_v[0] = 1'b0;
        wait_done(0, lat);
        chk("back-to-back latency", 32'(lat), 32'd5);
        check_lit("back-to-back", 32'h0000_0031, 1'b0, 1'b0, 1'b0);

        // Reset during the second RUN cycle
        @(posedge clk);
        #2;
        a_v[0] = 32'hAAAA_AAAA; b_v[0] = 32'h5555_5555; cin_v[0] = 1'b1; sub_v[0] = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #2;
        start_v[0] = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check_lit("mid reset", 32'h0, 1'b0, 1'b0, 1'b0);
        chk1("mid reset busy", busy_v[0], 1'b0);
        chk1("mid reset done", done_v[0], 1'b0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[0]) seen = 1'b1;
        end
        chk1("no done after reset", seen, 1'b0);

        run_op(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, lat);
        chk("post reset latency", 32'(lat), 32'd5);
        check_lit("post reset", 32'h1010_1011, 1'b0, 1'b0, 1'b0);

        // Random operations on every configuration; the model checks results
        for (int k = 0; k < 4; k++) begin
            int n_ops;
            n_ops = (k == 0) ? 50 : 1000;
            for (int i = 0; i < n_ops; i++) begin
                run_op(k, $urandom, $urandom, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), lat);
                chk($sformatf("k%0d latency", k), 32'(lat), 32'(cfg_nch(k) + 1));
            end
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
